// File: rtl/tdc_symbol_decoder.sv
// ---------------------------------------------------------------------------
// tdc_symbol_decoder
//
// Receive-side demodulator for the supply-activity covert channel. Every
// clkSample cycle the raw TDC delay-line snapshot is reduced to a tap count.
// The counts are averaged over a symbol window of S = 2**g_SYM_LOG2 samples
// and compared against a threshold, giving one bit per symbol. Bits are then
// packed MSB-first into bytes.
//
// Ports
//   clkSample  in   1    the only clock
//   rst        in   1    synchronous, active-high reset
//   clkProp    in   g_LEN  TDC snapshot, one per cycle
//   threshold  in   PCW  decision level (bit = mean < threshold)
//   sync       in   1    pulse marking the first sample of a frame
//   bit_out    out  1    decided symbol bit (held between strobes)
//   bit_valid  out  1    one-cycle strobe for bit_out / sym_level
//   sym_level  out  PCW  mean tap count of the last completed symbol
//   byte_out   out  8    assembled byte, MSB = first bit received
//   byte_valid out  1    one-cycle strobe for byte_out
//
// PCW = clog2(g_LEN+1).
// Latency: with sync in cycle 0, symbol k strobes in cycle (k+1)*S + 2.
// ---------------------------------------------------------------------------
module tdc_symbol_decoder #(
    parameter int g_LEN      = 32,
    parameter int g_SYM_LOG2 = 10
) (
    input  logic                         clkSample,
    input  logic                         rst,
    input  logic [g_LEN-1:0]             clkProp,
    input  logic [$clog2(g_LEN+1)-1:0]   threshold,
    input  logic                         sync,
    output logic                         bit_out,
    output logic                         bit_valid,
    output logic [$clog2(g_LEN+1)-1:0]   sym_level,
    output logic [7:0]                   byte_out,
    output logic                         byte_valid
);

    localparam int PCW  = $clog2(g_LEN + 1);
    // Holds S * g_LEN without overflow because g_LEN < 2**PCW.
    localparam int ACCW = PCW + g_SYM_LOG2;
    localparam int CNTW = g_SYM_LOG2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACQ  = 1'b1;

    localparam logic [CNTW-1:0] CNT_LAST = {CNTW{1'b1}};

    // ---------------- Front-end pipeline ----------------
    logic [g_LEN-1:0] samp_q;
    logic             sync_p1_q;
    logic [PCW-1:0]   pc_q;
    logic             sync_p2_q;
    logic [PCW-1:0]   pc_sum;

    // Popcount rather than leading-one detection so thermometer bubbles
    // do not corrupt the tap count.
    always_comb begin
        pc_sum = '0;
        for (int i = 0; i < g_LEN; i++) begin
            pc_sum = pc_sum + PCW'(samp_q[i]);
        end
    end

    always_ff @(posedge clkSample) begin
        if (rst) begin
            samp_q    <= '0;
            sync_p1_q <= 1'b0;
            pc_q      <= '0;
            sync_p2_q <= 1'b0;
        end else begin
            samp_q    <= clkProp;
            sync_p1_q <= sync;
            pc_q      <= pc_sum;
            sync_p2_q <= sync_p1_q;
        end
    end

    // ---------------- Symbol / byte state ----------------
    logic [0:0]      state_q,      state_d;
    logic [ACCW-1:0] acc_q,        acc_d;
    logic [CNTW-1:0] cnt_q,        cnt_d;
    logic [2:0]      bitcnt_q,     bitcnt_d;
    logic [7:0]      shift_q,      shift_d;
    logic            bit_out_q,    bit_out_d;
    logic            bit_valid_q,  bit_valid_d;
    logic [PCW-1:0]  sym_level_q,  sym_level_d;
    logic [7:0]      byte_out_q,   byte_out_d;
    logic            byte_valid_q, byte_valid_d;

    logic [ACCW-1:0] sum_full;
    logic [PCW-1:0]  mean;
    logic            sym_bit;

    // The symbol's last sample is folded in directly so the decision is
    // made in the same cycle that sample arrives.
    assign sum_full = acc_q + ACCW'(pc_q);
    assign mean     = PCW'(sum_full >> g_SYM_LOG2);
    // Fewer taps means more activity, which encodes a 1.
    assign sym_bit  = (mean < threshold);

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        bit_out_d    = bit_out_q;
        bit_valid_d  = 1'b0;
        sym_level_d  = sym_level_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sync_p2_q) begin
                    // The sample travelling with sync is sample 0.
                    state_d  = ST_ACQ;
                    acc_d    = ACCW'(pc_q);
                    cnt_d    = CNTW'(1);
                    bitcnt_d = 3'd0;
                    shift_d  = 8'd0;
                end
            end
            ST_ACQ: begin
                if (sync_p2_q) begin
                    // Resync discards the partial symbol and byte; it also
                    // overrides a symbol completing in this same cycle.
                    acc_d    = ACCW'(pc_q);
                    cnt_d    = CNTW'(1);
                    bitcnt_d = 3'd0;
                    shift_d  = 8'd0;
                end else if (cnt_q == CNT_LAST) begin
                    acc_d       = '0;
                    cnt_d       = '0;
                    sym_level_d = mean;
                    bit_out_d   = sym_bit;
                    bit_valid_d = 1'b1;
                    shift_d     = {shift_q[6:0], sym_bit};
                    bitcnt_d    = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        byte_out_d   = {shift_q[6:0], sym_bit};
                        byte_valid_d = 1'b1;
                    end
                end else begin
                    acc_d = sum_full;
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkSample) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            sym_level_q  <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            sym_level_q  <= sym_level_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign sym_level  = sym_level_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;

endmodule
